// File: rtl/e20_pkg.sv
// Shared definitions for the E20 run controller.
// Holds the controller state encoding, the dump-stream state encoding, the
// E20 default geometry constants and two small helpers.
package e20_pkg;

  localparam int E20_ADDR_W     = 13;
  localparam int E20_DATA_W     = 16;
  localparam int E20_NUM_REGS   = 8;
  localparam int E20_MAX_CYCLES = 100000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_SETTLE,
    ST_DUMP_REG,
    ST_DUMP_MEM,
    ST_DONE
  } e20_state_t;

  typedef enum logic [1:0] {
    DS_IDLE,  // ready to take a word request
    DS_WAIT,  // RAM read in flight
    DS_FULL   // word presented on the stream
  } e20_ds_state_t;

  // Width of a register selector; never narrower than one bit.
  function automatic int e20_sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [31:0] e20_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/e20_run_controller_if.sv
// Bundle of every non-clock signal of the E20 run controller.
// master : the controller side (drives core_reset, RAM port, dump stream, status)
// slave  : the environment side (start, program loader, core, RAM, registers, sink)
// Signals: start; load_valid/ready/addr/data/last; core_reset/core_halt;
//          mem_we/addr/wdata/rdata; reg_sel/reg_rdata;
//          dump_valid/ready/data/last; busy/done/timeout/cycles.
interface e20_run_controller_if
  import e20_pkg::*;
#(
  parameter int ADDR_W   = E20_ADDR_W,
  parameter int DATA_W   = E20_DATA_W,
  parameter int NUM_REGS = E20_NUM_REGS
);
  localparam int SEL_W = e20_sel_width(NUM_REGS);

  logic              start;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              core_reset;
  logic              core_halt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [SEL_W-1:0]  reg_sel;
  logic [DATA_W-1:0] reg_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [31:0]       cycles;

  modport master (
    input  start, load_valid, load_addr, load_data, load_last,
           core_halt, mem_rdata, reg_rdata, dump_ready,
    output load_ready, core_reset, mem_we, mem_addr, mem_wdata,
           reg_sel, dump_valid, dump_data, dump_last,
           busy, done, timeout, cycles
  );

  modport slave (
    output start, load_valid, load_addr, load_data, load_last,
           core_halt, mem_rdata, reg_rdata, dump_ready,
    input  load_ready, core_reset, mem_we, mem_addr, mem_wdata,
           reg_sel, dump_valid, dump_data, dump_last,
           busy, done, timeout, cycles
  );

endinterface

// File: rtl/e20_dump_stream.sv
// One-word output stage for the result dump.
// A request either carries its data directly (registers, cycle count) or
// asks for the RAM word whose read is issued in the request cycle; that word
// is captured after the one-cycle read latency. The captured word is held
// on the stream until the sink accepts it.
// Ports:
//   clock, reset      : clock, async active-high reset
//   i_req             : request a new word (only honoured when o_idle)
//   i_from_mem        : word comes from i_mem_rdata one cycle later
//   i_data, i_last    : direct word value, final-word flag
//   i_mem_rdata       : RAM read data
//   i_ready           : sink ready
//   o_idle            : stage empty, a request may be issued
//   o_fire            : handshake this cycle
//   o_valid/o_data/o_last : stream outputs
module e20_dump_stream
  import e20_pkg::*;
#(
  parameter int DATA_W = E20_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_from_mem,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_ready,
  output logic              o_idle,
  output logic              o_fire,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);

  e20_ds_state_t     r_state;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= DS_IDLE;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        DS_IDLE: begin
          if (i_req) begin
            r_last <= i_last;
            if (i_from_mem) begin
              r_state <= DS_WAIT;
            end else begin
              r_data  <= i_data;
              r_state <= DS_FULL;
            end
          end
        end
        DS_WAIT: begin
          r_data  <= i_mem_rdata;
          r_state <= DS_FULL;
        end
        DS_FULL: begin
          if (i_ready) begin
            r_state <= DS_IDLE;
            r_last  <= 1'b0;
          end
        end
        default: r_state <= DS_IDLE;
      endcase
    end
  end

  assign o_idle  = (r_state == DS_IDLE);
  assign o_valid = (r_state == DS_FULL);
  assign o_fire  = o_valid && i_ready;
  assign o_data  = r_data;
  // Last flag only ever shows alongside a valid word.
  assign o_last  = o_valid && r_last;

endmodule

// File: rtl/e20_run_controller.sv
// Sequencer for one E20 program run: clear RAM, load a program, hold the
// core in reset, let it run until halt or timeout, then stream out the cycle
// count, the core registers and the first DUMP_WORDS RAM words.
// Ports:
//   clock, reset : clock, async active-high reset
//   bus          : e20_run_controller_if master (loader, core, RAM,
//                  register peek, dump stream, run status)
module e20_run_controller
  import e20_pkg::*;
#(
  parameter int ADDR_W     = E20_ADDR_W,
  parameter int DATA_W     = E20_DATA_W,
  parameter int NUM_REGS   = E20_NUM_REGS,
  parameter int RESET_HOLD = 5,
  parameter int MAX_CYCLES = E20_MAX_CYCLES,
  parameter int DUMP_WORDS = 128
) (
  input  logic                 clock,
  input  logic                 reset,
  e20_run_controller_if.master bus
);

  localparam int                SEL_W        = e20_sel_width(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR    = '1;
  localparam logic [31:0]       MAX_CNT      = 32'(MAX_CYCLES);
  localparam logic [31:0]       HOLD_LAST    = 32'(RESET_HOLD - 1);
  localparam logic [31:0]       REG_LAST_IDX = 32'(NUM_REGS + 1);
  localparam logic [31:0]       MEM_LAST_IDX = 32'(DUMP_WORDS - 1);

  e20_state_t        r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [31:0]       r_hold_cnt;
  logic              r_settle;
  logic [31:0]       r_idx;
  logic [31:0]       r_cycles;
  logic              r_done;
  logic              r_timeout;

  logic              w_load_fire;
  logic              w_dumping;
  logic              w_from_mem;
  logic              w_req;
  logic              w_last;
  logic [31:0]       w_cycles_inc;
  logic [31:0]       w_reg_idx;
  logic [SEL_W-1:0]  w_reg_sel;
  logic [DATA_W-1:0] w_word;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_stream_idle;
  logic              w_fire;
  logic              w_dump_valid;
  logic [DATA_W-1:0] w_dump_data;
  logic              w_dump_last;

  assign w_load_fire  = (r_state == ST_LOAD) && bus.load_valid;
  assign w_dumping    = (r_state == ST_DUMP_REG) || (r_state == ST_DUMP_MEM);
  assign w_from_mem   = (r_state == ST_DUMP_MEM);
  // A new word is requested as soon as the output stage has emptied.
  assign w_req        = w_dumping && w_stream_idle;
  assign w_last       = w_from_mem && (r_idx == MEM_LAST_IDX);
  assign w_cycles_inc = e20_sat_inc(r_cycles);
  // Dump words 0 and 1 are the cycle count; registers start at word 2.
  assign w_reg_idx    = r_idx - 32'd2;
  assign w_reg_sel    = w_reg_idx[SEL_W-1:0];

  always_comb begin
    w_word = bus.reg_rdata;
    if (r_idx == 32'd0) begin
      w_word = DATA_W'(r_cycles[31:16]);
    end else if (r_idx == 32'd1) begin
      w_word = DATA_W'(r_cycles[15:0]);
    end
  end

  always_comb begin
    w_mem_addr  = r_idx[ADDR_W-1:0];
    w_mem_wdata = '0;
    case (r_state)
      ST_CLEAR: w_mem_addr = r_clr_addr;
      ST_LOAD: begin
        w_mem_addr  = bus.load_addr;
        w_mem_wdata = bus.load_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_clr_addr <= '0;
      r_hold_cnt <= '0;
      r_settle   <= 1'b0;
      r_idx      <= '0;
      r_cycles   <= '0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state    <= ST_CLEAR;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_cycles   <= '0;
            r_clr_addr <= '0;
            r_hold_cnt <= '0;
            r_idx      <= '0;
          end
        end
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + ADDR_W'(1);
          if (r_clr_addr == LAST_ADDR) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_load_fire && bus.load_last) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state <= ST_RUN;
          end else begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
          end
        end
        ST_RUN: begin
          // The halting cycle still counts as a run cycle.
          r_cycles <= w_cycles_inc;
          if (bus.core_halt) begin
            r_state   <= ST_SETTLE;
            r_timeout <= 1'b0;
            r_settle  <= 1'b0;
          end else if (w_cycles_inc >= MAX_CNT) begin
            r_state   <= ST_SETTLE;
            r_timeout <= 1'b1;
            r_settle  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          r_settle <= 1'b1;
          if (r_settle) begin
            r_state <= ST_DUMP_REG;
            r_idx   <= '0;
          end
        end
        ST_DUMP_REG: begin
          if (w_fire) begin
            if (r_idx == REG_LAST_IDX) begin
              r_state <= ST_DUMP_MEM;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 32'd1;
            end
          end
        end
        ST_DUMP_MEM: begin
          if (w_fire) begin
            if (r_idx == MEM_LAST_IDX) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 32'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  e20_dump_stream #(
    .DATA_W (DATA_W)
  ) u_dump_stream (
    .clock       (clock),
    .reset       (reset),
    .i_req       (w_req),
    .i_from_mem  (w_from_mem),
    .i_data      (w_word),
    .i_last      (w_last),
    .i_mem_rdata (bus.mem_rdata),
    .i_ready     (bus.dump_ready),
    .o_idle      (w_stream_idle),
    .o_fire      (w_fire),
    .o_valid     (w_dump_valid),
    .o_data      (w_dump_data),
    .o_last      (w_dump_last)
  );

  assign bus.load_ready = (r_state == ST_LOAD);
  assign bus.core_reset = !((r_state == ST_RUN) || (r_state == ST_SETTLE));
  assign bus.mem_we     = (r_state == ST_CLEAR) || w_load_fire;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.reg_sel    = w_reg_sel;
  assign bus.dump_valid = w_dump_valid;
  assign bus.dump_data  = w_dump_data;
  assign bus.dump_last  = w_dump_last;
  assign bus.busy       = !((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign bus.done       = r_done;
  assign bus.timeout    = r_timeout;
  assign bus.cycles     = r_cycles;

endmodule

// File: tb/tb_e20_run_controller.sv
module tb_e20_run_controller;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 8;
  localparam int RESET_HOLD = 5;
  localparam int MAX_CYCLES = 50;
  localparam int DUMP_WORDS = 16;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int N_DUMP     = 2 + NUM_REGS + DUMP_WORDS;

  typedef struct {
    int          prog;
    bit          preload;
    bit          halt_en;
    int          halt_at;
    bit          rnd_ready;
    bit          poke_start;
    logic [31:0] exp_cycles;
    logic        exp_timeout;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic              last;
  } lw_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  e20_run_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) bus ();

  e20_run_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
    .RESET_HOLD(RESET_HOLD), .MAX_CYCLES(MAX_CYCLES), .DUMP_WORDS(DUMP_WORDS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // RAM model: registered read, optional fill with 0xFFFF.
  logic [15:0] ram [DEPTH];
  bit          preload_req = 1'b0;
  always @(posedge clock) begin
    if (preload_req) begin
      for (int j = 0; j < DEPTH; j++) ram[j] <= 16'hFFFF;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Register file model: register i reads 0x00A0 + i.
  assign bus.reg_rdata = 16'h00A0 + 16'(bus.reg_sel);

  // Core model: counts cycles out of reset, halts on its halt_at-th cycle.
  bit          halt_en = 1'b0;
  int          halt_at = 0;
  logic [31:0] core_cnt;
  always @(posedge clock) begin
    if (bus.core_reset) core_cnt <= '0;
    else                core_cnt <= core_cnt + 32'd1;
  end
  assign bus.core_halt = halt_en && (core_cnt >= 32'(halt_at - 1));

  // Sink: always ready, or ready about 30% of cycles.
  bit rnd_ready = 1'b0;
  always @(negedge clock) begin
    bus.dump_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Stream monitor: captures handshakes, checks hold-under-stall, counts writes.
  logic [15:0] dq [$];
  logic        lq [$];
  int          stall_err = 0;
  int          we_count  = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;
  always @(posedge clock) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!bus.dump_valid || bus.dump_data !== prev_data ||
                         bus.dump_last !== prev_last)) stall_err++;
      if (bus.dump_valid && bus.dump_ready) begin
        dq.push_back(bus.dump_data);
        lq.push_back(bus.dump_last);
      end
      if (bus.mem_we) we_count++;
      prev_stall <= bus.dump_valid && !bus.dump_ready;
      prev_data  <= bus.dump_data;
      prev_last  <= bus.dump_last;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_core_reset"}, 32'(bus.core_reset), 32'd1);
    chk({tag, "_load_ready"}, 32'(bus.load_ready), 32'd0);
    chk({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
    chk({tag, "_dump_valid"}, 32'(bus.dump_valid), 32'd0);
    chk({tag, "_dump_last"},  32'(bus.dump_last),  32'd0);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    chk({tag, "_done"},       32'(bus.done),       32'd0);
    chk({tag, "_timeout"},    32'(bus.timeout),    32'd0);
    chk({tag, "_cycles"},     bus.cycles,          32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id, input bit abort);
    lw_t         words [$];
    logic [15:0] img [DEPTH];
    logic [15:0] exp_w;
    int          n;
    case (v.prog)
      0: begin
        words.push_back('{addr: 6'd0, data: 16'h2081, last: 1'b0});
        words.push_back('{addr: 6'd1, data: 16'h4001, last: 1'b0});
        words.push_back('{addr: 6'd2, data: 16'h4002, last: 1'b1});
      end
      1: words.push_back('{addr: 6'd5, data: 16'hBEEF, last: 1'b1});
      default: begin
        words.push_back('{addr: 6'd3, data: 16'h1111, last: 1'b0});
        words.push_back('{addr: 6'd7, data: 16'h00C3, last: 1'b0});
        words.push_back('{addr: 6'd3, data: 16'h2222, last: 1'b1});
      end
    endcase
    for (int j = 0; j < DEPTH; j++) img[j] = 16'h0000;
    foreach (words[k]) img[words[k].addr] = words[k].data;

    halt_en   = v.halt_en;
    halt_at   = v.halt_at;
    rnd_ready = v.rnd_ready;
    if (v.preload) begin
      @(negedge clock); preload_req = 1'b1;
      @(negedge clock); preload_req = 1'b0;
    end
    dq.delete(); lq.delete();
    stall_err = 0;
    we_count  = 0;

    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    chk($sformatf("v%0d_busy_after_start", id), 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.load_ready && n < 500) begin @(negedge clock); n++; end
    chk($sformatf("v%0d_load_ready_wait", id), 32'(bus.load_ready), 32'd1);

    foreach (words[k]) begin
      bus.load_valid = 1'b1;
      bus.load_addr  = words[k].addr;
      bus.load_data  = words[k].data;
      bus.load_last  = words[k].last;
      @(negedge clock);
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;

    n = 0;
    while (bus.core_reset && n < 100) begin n++; @(negedge clock); end
    chk($sformatf("v%0d_hold_len", id), 32'(n), 32'(RESET_HOLD));

    if (v.poke_start) begin
      bus.start = 1'b1; @(negedge clock); bus.start = 1'b0;
    end

    if (abort) begin
      n = 0;
      while (dq.size() < 2 + NUM_REGS + 3 && n < 3000) begin @(negedge clock); n++; end
      chk($sformatf("v%0d_abort_busy", id), 32'(bus.busy), 32'd1);
      #2 reset = 1'b1;
      #1 check_reset_vals($sformatf("v%0d_middump", id));
      @(negedge clock); reset = 1'b0;
      $display("vec %0d: reset during dump after %0d words", id, dq.size());
      return;
    end

    n = 0;
    while (!bus.done && n < 5000) begin @(negedge clock); n++; end
    chk($sformatf("v%0d_done", id),      32'(bus.done),       32'd1);
    chk($sformatf("v%0d_busy_end", id),  32'(bus.busy),       32'd0);
    chk($sformatf("v%0d_core_reset", id), 32'(bus.core_reset), 32'd1);
    chk($sformatf("v%0d_timeout", id),   32'(bus.timeout),    32'(v.exp_timeout));
    chk($sformatf("v%0d_cycles", id),    bus.cycles,          v.exp_cycles);
    chk($sformatf("v%0d_n_words", id),   32'(dq.size()),      32'(N_DUMP));
    chk($sformatf("v%0d_stall_hold", id), 32'(stall_err),     32'd0);
    chk($sformatf("v%0d_we_count", id),  32'(we_count),       32'(DEPTH + words.size()));
    for (int j = 0; j < N_DUMP && j < dq.size(); j++) begin
      if (j == 0)                 exp_w = v.exp_cycles[31:16];
      else if (j == 1)            exp_w = v.exp_cycles[15:0];
      else if (j < 2 + NUM_REGS)  exp_w = 16'h00A0 + 16'(j - 2);
      else                        exp_w = img[j - 2 - NUM_REGS];
      chk($sformatf("v%0d_word%0d", id, j), 32'(dq[j]), 32'(exp_w));
      chk($sformatf("v%0d_last%0d", id, j), 32'(lq[j]), 32'(j == N_DUMP - 1));
    end
    @(negedge clock);
    chk($sformatf("v%0d_done_held", id), 32'(bus.done), 32'd1);
    $display("vec %0d: cycles=%0d timeout=%0d words=%0d", id, bus.cycles, bus.timeout, dq.size());
  endtask

  vec_t vecs [6];

  initial begin
    int n;
    //          prog pre halt at  rnd poke cycles  tmo
    vecs[0] = '{0,   0,  1,  7,   0,  0,   32'd7,  1'b0};
    vecs[1] = '{0,   0,  0,  0,   0,  0,   32'd50, 1'b1};
    vecs[2] = '{1,   1,  1,  7,   0,  0,   32'd7,  1'b0};
    vecs[3] = '{2,   0,  1,  20,  1,  1,   32'd20, 1'b0};
    vecs[4] = '{0,   0,  1,  50,  0,  0,   32'd50, 1'b0};
    vecs[5] = '{1,   1,  0,  0,   1,  0,   32'd50, 1'b1};

    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i, 1'b0);

    // Reset in the middle of LOAD.
    halt_en = 1'b1; halt_at = 7; rnd_ready = 1'b0;
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    n = 0;
    while (!bus.load_ready && n < 500) begin @(negedge clock); n++; end
    chk("midload_ready", 32'(bus.load_ready), 32'd1);
    bus.load_valid = 1'b1; bus.load_addr = 6'd9; bus.load_data = 16'h5555; bus.load_last = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1; bus.load_valid = 1'b0;
    #1 check_reset_vals("midload");
    @(negedge clock); reset = 1'b0;
    $display("seq midload: reset while loading");

    // Reset in the middle of DUMP_MEM, then a clean run.
    run_vec(vecs[0], 6, 1'b1);
    run_vec(vecs[0], 7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/e20_run_controller.md
E20_RUN_CONTROLLER -- requirements
Module: e20_run_controller

Interface
REQ-001 Parameter ADDR_W, default 13: E20 RAM address width; RAM depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 16: RAM and register word width.
REQ-003 Parameter NUM_REGS, default 8: number of core registers dumped.
REQ-004 Parameter RESET_HOLD, default 5: number of cycles core_reset is held after load.
REQ-005 Parameter MAX_CYCLES, default 100000: run timeout in cycles.
REQ-006 Parameter DUMP_WORDS, default 128: number of RAM words dumped from address 0.
REQ-007 Clock and reset: one clock, named clock; reset is asynchronous and active-high, named reset.
REQ-008 Ports (name, direction, width, meaning):
- clock  in  1  clock.
- reset  in  1  async active-high reset.
- start  in  1  one-cycle pulse that begins a run; accepted only in IDLE or DONE.
- load_valid/load_ready  in/out  1/1  program word handshake.
- load_addr/load_data/load_last  in  ADDR_W/DATA_W/1  word address, word value, final word.
- core_reset  out  1  reset to the processor.
- core_halt  in  1  processor halt.
- mem_we/mem_addr/mem_wdata  out  1/ADDR_W/DATA_W  RAM write/read port.
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency.
- reg_sel/reg_rdata  out/in  clog2(NUM_REGS)/DATA_W  combinational register peek.
- dump_valid/dump_ready  out/in  1/1  result stream handshake.
- dump_data/dump_last  out  DATA_W/1  result word, final word.
- busy/done/timeout  out  1/1/1  run status.
- cycles  out  32  run cycle count.

Function
REQ-009 States: IDLE, CLEAR, LOAD, HOLD, RUN, SETTLE, DUMP_REG, DUMP_MEM, DONE.
REQ-010 Sequence: start -> CLEAR, clearing done and timeout and zeroing cycles.
REQ-011 CLEAR writes 0 to addresses 0..2**ADDR_W-1, one per cycle, then enters LOAD.
REQ-012 LOAD: load_ready=1. On each load_valid&&load_ready, write load_data to load_addr in that same cycle.
REQ-013 LOAD exits to HOLD on the handshake that carries load_last; addresses may repeat, and the last write wins.
REQ-014 HOLD keeps core_reset=1 for exactly RESET_HOLD cycles, then enters RUN.
REQ-015 core_reset=1 in every state except RUN and SETTLE.
REQ-016 RUN increments cycles every cycle.
- core_halt=1 -> SETTLE, timeout=0.
- cycles reaching MAX_CYCLES without halt -> SETTLE, timeout=1.
- If both occur in the same cycle, halt wins.
REQ-017 SETTLE lasts 2 cycles with the core still running, then enters DUMP_REG. cycles is frozen from SETTLE onward.
REQ-018 DUMP_REG emits cycles[31:16], then cycles[15:0], then reg_rdata for registers 0..NUM_REGS-1, then enters DUMP_MEM.
REQ-019 DUMP_MEM emits RAM words 0..DUMP_WORDS-1:
- Read issued, one-cycle wait, then dump_valid asserted.
- Minimum 2 cycles per word.
REQ-020 dump_last=1 only on RAM word DUMP_WORDS-1.
REQ-021 Stream rules: dump_data and dump_last are stable while dump_valid && !dump_ready; a word advances only on dump_valid&&dump_ready.
REQ-022 After the last handshake, enter DONE with done=1. done holds until the next start.
REQ-023 busy=1 in all states except IDLE and DONE.
REQ-024 start while busy is ignored.
REQ-025 mem_we=1 only in CLEAR and on accepted LOAD handshakes.
REQ-026 load_ready=0 outside LOAD.
REQ-027 The cycles counter saturates at 2**32-1.

Reset
REQ-028 Asserting reset at any time returns to IDLE within the same cycle, abandoning any transfer in progress.
REQ-029 Reset values: core_reset=1, load_ready=0, mem_we=0, dump_valid=0, dump_last=0, busy=0, done=0, timeout=0, cycles=0; address counters are 0.

Structure
REQ-030 A shared package e20_pkg holds:
- the state enum;
- the E20 default constants: ADDR_W=13, NUM_REGS=8, MAX_CYCLES=100000.
REQ-031 One sub-module, e20_dump_stream, holds the read-latency and valid/ready output holding logic used by DUMP_REG and DUMP_MEM.

Verification
REQ-032 Load 3 words {0:0x2081, 1:0x4001, 2:0x4002 (halt loop)} with a halting core model; core halts after 7 RUN cycles -> timeout=0, cycles=7, first two dump words are 0x0000 and 0x0007.
REQ-033 Core never halts, with MAX_CYCLES=50 -> timeout=1, cycles=50, done=1 after 2+NUM_REGS+DUMP_WORDS handshakes.
REQ-034 Preload RAM with 0xFFFF, then load a single word at address 5 -> dumped word 5 equals the loaded value and all other dumped words are 0x0000.
REQ-035 dump_ready toggled randomly with 30% duty -> no word is lost or duplicated, and data is stable under stall.
REQ-036 Reset asserted mid-LOAD and mid-DUMP_MEM -> IDLE immediately with all REQ-029 values; a new start completes a correct run.
REQ-037 core_halt and the timeout condition in the same cycle -> timeout=0.
